// File: rtl/fp_divider.sv
// fp_divider: iterative IEEE-754 single-precision divider, Q = A / B.
// Restoring division retires RADIX_BITS quotient bits per cycle (1 or 2),
// followed by a single normalize/round/special-case cycle.
// Subnormal inputs are treated as signed zero; subnormal results flush to zero.
// Build option: define FP_DIV_RNE_EN for round-to-nearest-even; otherwise the
// mantissa is truncated toward zero.
module fp_divider #(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        valid,
    output logic [31:0] Q,
    output logic [3:0]  flags
);

    localparam int          DIV_CYCLES = 26 / RADIX_BITS;
    localparam logic [4:0]  LAST_CYCLE = 5'(DIV_CYCLES - 1);
    localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [24:0] rem;
    logic [24:0] rem_next;
    logic [25:0] quo;
    logic [25:0] quo_next;
    logic [4:0]  cnt;
    logic [24:0] mb_ext;

    // Operand classification on the latched operands
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic        sign;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    logic signed [9:0] e_raw;
    logic signed [9:0] e_fin;
    logic [22:0]       mant;
    logic [22:0]       mant_fin;
`ifdef FP_DIV_RNE_EN
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic              carry;
`endif

    logic [31:0] res_q;
    logic [3:0]  res_flags;

    assign exp_a  = a_q[30:23];
    assign exp_b  = b_q[30:23];
    assign sign   = a_q[31] ^ b_q[31];
    assign a_zero = (exp_a == 8'h00);
    assign b_zero = (exp_b == 8'h00);
    assign a_inf  = (exp_a == 8'hFF) && (a_q[22:0] == 23'h0);
    assign b_inf  = (exp_b == 8'hFF) && (b_q[22:0] == 23'h0);
    assign a_nan  = (exp_a == 8'hFF) && (a_q[22:0] != 23'h0);
    assign b_nan  = (exp_b == 8'hFF) && (b_q[22:0] != 23'h0);
    assign mb_ext = {2'b01, b_q[22:0]};

    assign busy  = (state == DIVIDE) || (state == NORM);
    assign valid = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; start is only honoured in IDLE and DONE
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = DIVIDE;
                end
            end
            DIVIDE: begin
                if (cnt == LAST_CYCLE) state_next = NORM;
            end
            NORM: state_next = DONE;
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = DIVIDE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch and iteration registers
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are deliberately not reset; they are
        // always loaded on accept before the FSM ever consumes them.
        if (accept) begin
            a_q <= A;
            b_q <= B;
            rem <= {2'b01, A[22:0]};
            quo <= '0;
            cnt <= '0;
        end else if (state == DIVIDE) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 5'd1;
        end
    end

    // Restoring division step, unrolled RADIX_BITS times per cycle
    always_comb begin
        rem_next = rem;
        quo_next = quo;
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (rem_next >= mb_ext) begin
                rem_next = (rem_next - mb_ext) << 1;
                quo_next = {quo_next[24:0], 1'b1};
            end else begin
                rem_next = rem_next << 1;
                quo_next = {quo_next[24:0], 1'b0};
            end
        end
    end

    // Normalize the quotient, pick the biased exponent, then round
    always_comb begin
        if (quo[25]) begin
            mant  = quo[24:2];
            e_raw = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd127;
        end else begin
            mant  = quo[23:1];
            e_raw = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd126;
        end
`ifdef FP_DIV_RNE_EN
        guard    = quo[25] ? quo[1] : quo[0];
        sticky   = quo[25] ? (quo[0] | (|rem)) : (|rem);
        round_up = guard & (sticky | mant[0]);
        {carry, mant_fin} = {1'b0, mant} + {23'h0, round_up};
        e_fin    = carry ? e_raw + 10'sd1 : e_raw;
`else
        mant_fin = mant;
        e_fin    = e_raw;
`endif
    end

    // Special cases override the datapath; then exponent range checks
    always_comb begin
        res_q     = {sign, e_fin[7:0], mant_fin};
        res_flags = 4'b0000;
        if (a_nan || b_nan) begin
            res_q = CANON_NAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            res_q     = CANON_NAN;
            res_flags = 4'b1000;
        end else if (a_inf) begin
            res_q = {sign, 8'hFF, 23'h0};
        end else if (b_zero) begin
            res_q     = {sign, 8'hFF, 23'h0};
            res_flags = 4'b0100;
        end else if (b_inf || a_zero) begin
            res_q = {sign, 31'h0};
        end else if (e_fin >= 10'sd255) begin
            res_q     = {sign, 8'hFF, 23'h0};
            res_flags = 4'b0010;
        end else if (e_fin <= 10'sd0) begin
            res_q     = {sign, 31'h0};
            res_flags = 4'b0001;
        end
    end

    // Result registers, updated once per operation in NORM
    always_ff @(posedge clk) begin
        if (rst) begin
            Q     <= '0;
            flags <= '0;
        end else if (state == NORM) begin
            Q     <= res_q;
            flags <= res_flags;
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: self-checking bench for fp_divider. Two instances are used:
// radix-1 (27-edge latency) and radix-2 (14-edge latency). Random operands
// are compared against an arithmetic reference model (integer long division).
module tb_fp_divider;

`ifdef FP_DIV_RNE_EN
    localparam bit          RNE       = 1'b1;
    localparam logic [31:0] ONE_THIRD = 32'h3EAA_AAAB;
`else
    localparam bit          RNE       = 1'b0;
    localparam logic [31:0] ONE_THIRD = 32'h3EAA_AAAA;
`endif

    localparam int N_DIR = 12;
    localparam logic [31:0] DIR_A [N_DIR] = '{
        32'h40C0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000,
        32'h0000_0000, 32'h7FC0_0001, 32'h7F00_0000, 32'h0080_0000,
        32'h0000_0001, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000};
    localparam logic [31:0] DIR_B [N_DIR] = '{
        32'h4000_0000, 32'h4040_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h3F80_0000, 32'h3E80_0000, 32'h4000_0000,
        32'h3F80_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h7F80_0000};
    localparam logic [31:0] DIR_Q [N_DIR] = '{
        32'h4040_0000, ONE_THIRD,     32'h7F80_0000, 32'hFF80_0000,
        32'h7FC0_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000,
        32'h0000_0000, 32'h7F80_0000, 32'h8000_0000, 32'h7FC0_0000};
    localparam logic [3:0] DIR_F [N_DIR] = '{
        4'b0000, 4'b0000, 4'b0100, 4'b0100,
        4'b1000, 4'b0000, 4'b0010, 4'b0001,
        4'b0000, 4'b0000, 4'b0000, 4'b1000};

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start;
    logic [31:0] a_in [2];
    logic [31:0] b_in [2];
    logic [1:0]  busy;
    logic [1:0]  valid;
    logic [31:0] q_out [2];
    logic [3:0]  flags_out [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_divider #(.RADIX_BITS(1)) u_dut_r1 (
        .clk(clk), .rst(rst), .start(start[0]), .A(a_in[0]), .B(b_in[0]),
        .busy(busy[0]), .valid(valid[0]), .Q(q_out[0]), .flags(flags_out[0]));

    fp_divider #(.RADIX_BITS(2)) u_dut_r2 (
        .clk(clk), .rst(rst), .start(start[1]), .A(a_in[1]), .B(b_in[1]),
        .busy(busy[1]), .valid(valid[1]), .Q(q_out[1]), .flags(flags_out[1]));

    function automatic int latency_of(input int which);
        return 26 / (which + 1) + 1;
    endfunction

    // Reference model: returns {flags, Q}
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [7:0]        ea, eb;
        logic [22:0]       fa, fb;
        bit                an, bn, ai, bi, az, bz, g, st;
        longint unsigned   num, den, quo, rmd, mant;
        int                e;
        s  = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        an = (ea == 8'hFF) && (fa != 0);
        bn = (eb == 8'hFF) && (fb != 0);
        ai = (ea == 8'hFF) && (fa == 0);
        bi = (eb == 8'hFF) && (fb == 0);
        az = (ea == 8'h00);
        bz = (eb == 8'h00);
        if (an || bn) return {4'b0000, 32'h7FC0_0000};
        if ((az && bz) || (ai && bi)) return {4'b1000, 32'h7FC0_0000};
        if (ai) return {4'b0000, s, 8'hFF, 23'h0};
        if (bz) return {4'b0100, s, 8'hFF, 23'h0};
        if (bi || az) return {4'b0000, s, 31'h0};
        num = (longint'(fa) + 64'h80_0000) << 25;
        den = longint'(fb) + 64'h80_0000;
        quo = num / den;
        rmd = num % den;
        if (quo >= (64'd1 << 25)) begin
            mant = (quo >> 2) & 64'h7F_FFFF;
            g    = quo[1];
            st   = quo[0] || (rmd != 0);
            e    = int'(ea) - int'(eb) + 127;
        end else begin
            mant = (quo >> 1) & 64'h7F_FFFF;
            g    = quo[0];
            st   = (rmd != 0);
            e    = int'(ea) - int'(eb) + 126;
        end
        if (RNE && g && (st || mant[0])) mant = mant + 1;
        if (mant == 64'h80_0000) begin
            mant = 0;
            e    = e + 1;
        end
        if (e >= 255) return {4'b0010, s, 8'hFF, 23'h0};
        if (e <= 0)   return {4'b0001, s, 31'h0};
        return {4'b0000, s, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 11))
            0:       return {s, 31'h0};
            1:       return {s, 8'h00, 23'($urandom)};
            2:       return {s, 8'hFF, 23'h0};
            3:       return {s, 8'hFF, 23'($urandom) | 23'h1};
            4:       return {s, 8'($urandom_range(1, 24)), 23'($urandom)};
            5:       return {s, 8'($urandom_range(230, 254)), 23'($urandom)};
            6:       return {s, 8'($urandom_range(100, 150)), 23'h0};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    // Raise start with operands at the current time (caller is at a negedge)
    task automatic launch(input int which, input logic [31:0] a, input logic [31:0] b);
        start[which] = 1'b1;
        a_in[which]  = a;
        b_in[which]  = b;
    endtask

    // Wait for valid after a launch; optionally pulse start during cycles 3..10
    task automatic wait_done(input int which, input bit noise,
                             output logic [31:0] q, output logic [3:0] fl,
                             output int lat, output bit hs_ok, output bit timed_out);
        q = 'x; fl = 'x; lat = -1; timed_out = 1'b1;
        @(negedge clk);
        start[which] = 1'b0;
        a_in[which]  = $urandom;
        b_in[which]  = $urandom;
        hs_ok = busy[which] && !valid[which];
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (valid[which]) begin
                lat       = n;
                timed_out = 1'b0;
                q         = q_out[which];
                fl        = flags_out[which];
                if (busy[which]) hs_ok = 1'b0;
                break;
            end
            if (!busy[which]) hs_ok = 1'b0;
            if (noise) begin
                start[which] = (n >= 2 && n <= 9);
                a_in[which]  = $urandom;
                b_in[which]  = $urandom;
            end
        end
        start[which] = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 2'b00;
        for (int w = 0; w < 2; w++) begin
            a_in[w] = '0;
            b_in[w] = '0;
        end
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            n_tests++;
            if (busy[w] !== 1'b0 || valid[w] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: busy=%b valid=%b expected 0 0", w, busy[w], valid[w]);
            end
            n_tests++;
            if (q_out[w] !== 32'h0 || flags_out[w] !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_out[%0d]: Q=%08h flags=%b expected 00000000 0000", w, q_out[w], flags_out[w]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] q;
        logic [3:0]  fl;
        int          lat;
        bit          hs_ok, to;
        for (int i = 0; i < N_DIR; i++) begin
            @(negedge clk);
            launch(0, DIR_A[i], DIR_B[i]);
            wait_done(0, 1'b0, q, fl, lat, hs_ok, to);
            n_tests++;
            if (to || lat != 27 || !hs_ok) begin
                n_fail++;
                $display("FAIL directed[%0d] timing: latency=%0d timeout=%b handshake_ok=%b expected 27 0 1", i, lat, to, hs_ok);
            end
            n_tests++;
            if (q !== DIR_Q[i] || fl !== DIR_F[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] %08h/%08h: Q=%08h flags=%b expected %08h %b",
                         i, DIR_A[i], DIR_B[i], q, fl, DIR_Q[i], DIR_F[i]);
            end
            @(negedge clk);
            n_tests++;
            if (valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL directed[%0d] pulse: valid=%b busy=%b expected 0 0", i, valid[0], busy[0]);
            end
        end
    endtask

    task automatic test_random(input int which, input int count);
        logic [31:0] a, b, q;
        logic [3:0]  fl;
        logic [35:0] exp_r;
        int          lat;
        bit          hs_ok, to;
        for (int i = 0; i < count; i++) begin
            a = rand_operand();
            b = rand_operand();
            exp_r = model(a, b);
            @(negedge clk);
            launch(which, a, b);
            wait_done(which, 1'b0, q, fl, lat, hs_ok, to);
            n_tests++;
            if (to || lat != latency_of(which) || !hs_ok || q !== exp_r[31:0] || fl !== exp_r[35:32]) begin
                n_fail++;
                $display("FAIL random[r%0d #%0d] %08h/%08h: Q=%08h flags=%b lat=%0d hs=%b expected %08h %b lat=%0d",
                         which + 1, i, a, b, q, fl, lat, hs_ok, exp_r[31:0], exp_r[35:32], latency_of(which));
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] a, b, q;
        logic [3:0]  fl;
        logic [35:0] exp_r;
        int          lat;
        bit          hs_ok, to;
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 32'h40C0_0000 : rand_operand();
            b = (i == 0) ? 32'h4000_0000 : rand_operand();
            exp_r = model(a, b);
            @(negedge clk);
            launch(0, a, b);
            wait_done(0, 1'b1, q, fl, lat, hs_ok, to);
            n_tests++;
            if (to || lat != 27 || !hs_ok || q !== exp_r[31:0] || fl !== exp_r[35:32]) begin
                n_fail++;
                $display("FAIL ignore_start[%0d] %08h/%08h: Q=%08h flags=%b lat=%0d expected %08h %b lat=27",
                         i, a, b, q, fl, lat, exp_r[31:0], exp_r[35:32]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, q;
        logic [3:0]  fl;
        logic [35:0] exp1, exp2;
        int          lat;
        bit          hs_ok, to;
        a1 = 32'h3F80_0000; b1 = 32'h4040_0000;
        a2 = 32'h40C0_0000; b2 = 32'h4000_0000;
        exp1 = model(a1, b1);
        exp2 = model(a2, b2);
        @(negedge clk);
        launch(0, a1, b1);
        wait_done(0, 1'b0, q, fl, lat, hs_ok, to);
        n_tests++;
        if (to || q !== exp1[31:0] || fl !== exp1[35:32]) begin
            n_fail++;
            $display("FAIL b2b_first: Q=%08h flags=%b expected %08h %b", q, fl, exp1[31:0], exp1[35:32]);
        end
        // Still in the DONE cycle: a new request must be taken immediately
        launch(0, a2, b2);
        wait_done(0, 1'b0, q, fl, lat, hs_ok, to);
        n_tests++;
        if (to || lat != 27 || !hs_ok || q !== exp2[31:0] || fl !== exp2[35:32]) begin
            n_fail++;
            $display("FAIL b2b_second: Q=%08h flags=%b lat=%0d hs=%b expected %08h %b lat=27",
                     q, fl, lat, hs_ok, exp2[31:0], exp2[35:32]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        logic [3:0]  fl;
        int          lat, seen;
        bit          hs_ok, to;
        @(negedge clk);
        launch(0, 32'h3F80_0000, 32'h4040_0000);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy[0] !== 1'b0 || valid[0] !== 1'b0 || q_out[0] !== 32'h0 || flags_out[0] !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b valid=%b Q=%08h flags=%b expected 0 0 00000000 0000",
                     busy[0], valid[0], q_out[0], flags_out[0]);
        end
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid[0] || busy[0]) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_abort: %0d cycles with valid/busy after reset, expected 0", seen);
        end
        launch(0, 32'h40C0_0000, 32'h4000_0000);
        wait_done(0, 1'b0, q, fl, lat, hs_ok, to);
        n_tests++;
        if (to || lat != 27 || q !== 32'h4040_0000 || fl !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_recover: Q=%08h flags=%b lat=%0d expected 40400000 0000 lat=27", q, fl, lat);
        end
    endtask

    task automatic test_radix2();
        logic [31:0] q;
        logic [3:0]  fl;
        int          lat;
        bit          hs_ok, to;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            launch(1, DIR_A[i], DIR_B[i]);
            wait_done(1, 1'b0, q, fl, lat, hs_ok, to);
            n_tests++;
            if (to || lat != 14 || !hs_ok || q !== DIR_Q[i] || fl !== DIR_F[i]) begin
                n_fail++;
                $display("FAIL radix2[%0d] %08h/%08h: Q=%08h flags=%b lat=%0d hs=%b expected %08h %b lat=14",
                         i, DIR_A[i], DIR_B[i], q, fl, lat, hs_ok, DIR_Q[i], DIR_F[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_radix2();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random(0, 150);
        test_random(1, 80);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
